vram_write_arbiter: RTL

VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

---
 rtl/vram_pkg.sv | 27 ++
 rtl/vram_port_mux.sv | 65 ++++++
 rtl/vram_write_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM write arbiter and its port mux.
package vram_pkg;

  localparam int unsigned ADDR_W           = 11;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned VRAM_DEPTH       = 1200;
  localparam int unsigned CLR_TIMEOUT_DFLT = 2047;

  // First cell of the status-text area; the text writer owns cells from here on.
  localparam logic [ADDR_W-1:0] TXT_BASE_ADDR = 11'd120;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLR_START = 3'd1,
    ST_CLR_BUSY  = 3'd2,
    ST_GRANT_DRW = 3'd3,
    ST_GRANT_TXT = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CLR  = 2'd1,
    SRC_DRW  = 2'd2,
    SRC_TXT  = 2'd3
  } port_sel_t;

endpackage

// File: rtl/vram_port_mux.sv
// 3:1 select of the clear / drawer / text write ports onto the single VRAM
// write port, with an out-of-range address check on the selected write.
module vram_port_mux
  import vram_pkg::*;
#(
  parameter int unsigned DEPTH = VRAM_DEPTH
) (
  input  port_sel_t          sel,
  input  logic               clr_we,
  input  logic [ADDR_W-1:0]  clr_addr,
  input  logic [DATA_W-1:0]  clr_data,
  input  logic               drw_we,
  input  logic [ADDR_W-1:0]  drw_addr,
  input  logic [DATA_W-1:0]  drw_data,
  input  logic               txt_we,
  input  logic [ADDR_W-1:0]  txt_addr,
  input  logic [DATA_W-1:0]  txt_data,
  output logic               vram_we,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [DATA_W-1:0]  vram_data,
  output logic               addr_err
);

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              in_range;

  // Route the owning port; with no owner the VRAM port is held at zero.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    case (sel)
      SRC_CLR: begin
        sel_we   = clr_we;
        sel_addr = clr_addr;
        sel_data = clr_data;
      end
      SRC_DRW: begin
        sel_we   = drw_we;
        sel_addr = drw_addr;
        sel_data = drw_data;
      end
      SRC_TXT: begin
        sel_we   = txt_we;
        sel_addr = txt_addr;
        sel_data = txt_data;
      end
      default: begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
      end
    endcase
  end

  assign in_range  = ({{(32-ADDR_W){1'b0}}, sel_addr} < DEPTH);
  // Address and data still pass through on a bad write; only the strobe is blocked.
  assign vram_we   = sel_we & in_range;
  assign vram_addr = sel_addr;
  assign vram_data = sel_data;
  assign addr_err  = sel_we & ~in_range;

endmodule

// File: rtl/vram_write_arbiter.sv
// Arbitrates the single VRAM write port between the clear engine, the
// tile/map drawer and the status-text writer. Clearing always wins.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_IDLE      | port unowned, VRAM outputs zero, arbitration point
//   ST_CLR_START | one-cycle clr_start pulse, clear port owns VRAM
//   ST_CLR_BUSY  | waiting for clr_done low-then-high, or timeout
//   ST_GRANT_DRW | drawer owns VRAM until drw_req drops
//   ST_GRANT_TXT | text writer owns VRAM until txt_req drops
module vram_write_arbiter #(
  parameter int unsigned VRAM_DEPTH  = vram_pkg::VRAM_DEPTH,
  parameter int unsigned CLR_TIMEOUT = vram_pkg::CLR_TIMEOUT_DFLT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redraw,
  output logic                          clr_start,
  input  logic                          clr_we,
  input  logic [vram_pkg::ADDR_W-1:0]   clr_addr,
  input  logic [vram_pkg::DATA_W-1:0]   clr_data,
  input  logic                          clr_done,
  input  logic                          drw_req,
  input  logic                          drw_we,
  input  logic [vram_pkg::ADDR_W-1:0]   drw_addr,
  input  logic [vram_pkg::DATA_W-1:0]   drw_data,
  output logic                          drw_gnt,
  input  logic                          txt_req,
  input  logic                          txt_we,
  input  logic [vram_pkg::ADDR_W-1:0]   txt_addr,
  input  logic [vram_pkg::DATA_W-1:0]   txt_data,
  output logic                          txt_gnt,
  output logic                          vram_we,
  output logic [vram_pkg::ADDR_W-1:0]   vram_addr,
  output logic [vram_pkg::DATA_W-1:0]   vram_data,
  output logic                          busy,
  output logic                          fault
);

  import vram_pkg::*;

  localparam logic [10:0] TMO_LAST = 11'(CLR_TIMEOUT - 1);

  arb_state_t state;
  arb_state_t state_nxt;
  port_sel_t  port_sel;
  logic       rr_drw_first;
  logic       pending;
  logic       seen_low;
  logic [10:0] tmo_cnt;
  logic       addr_err;
  logic       clr_finish;
  logic       tmo_hit;
  logic       grant_drw_now;

  // A clear only finishes on a rising clr_done seen after it went low.
  assign clr_finish    = (state == ST_CLR_BUSY) && clr_done && seen_low;
  assign tmo_hit       = (state == ST_CLR_BUSY) && !clr_finish && (tmo_cnt >= TMO_LAST);
  assign grant_drw_now = drw_req && (rr_drw_first || !txt_req);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: clear requests beat draw requests, grants are never preempted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (redraw || pending)  state_nxt = ST_CLR_START;
        else if (grant_drw_now) state_nxt = ST_GRANT_DRW;
        else if (txt_req)       state_nxt = ST_GRANT_TXT;
      end
      ST_CLR_START: state_nxt = ST_CLR_BUSY;
      ST_CLR_BUSY:  if (clr_finish || tmo_hit) state_nxt = ST_IDLE;
      ST_GRANT_DRW: if (!drw_req) state_nxt = ST_IDLE;
      ST_GRANT_TXT: if (!txt_req) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state so reset immediately yields idle outputs.
  always_comb begin
    clr_start = 1'b0;
    drw_gnt   = 1'b0;
    txt_gnt   = 1'b0;
    port_sel  = SRC_NONE;
    case (state)
      ST_CLR_START: begin
        clr_start = 1'b1;
        port_sel  = SRC_CLR;
      end
      ST_CLR_BUSY:  port_sel = SRC_CLR;
      ST_GRANT_DRW: begin
        drw_gnt  = 1'b1;
        port_sel = SRC_DRW;
      end
      ST_GRANT_TXT: begin
        txt_gnt  = 1'b1;
        port_sel = SRC_TXT;
      end
      default: port_sel = SRC_NONE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Redraw seen outside IDLE waits here; IDLE always services it, a timeout drops it.
  always_ff @(posedge clk) begin
    if (rst)                              pending <= 1'b0;
    else if (state == ST_IDLE || tmo_hit) pending <= 1'b0;
    else if (redraw)                      pending <= 1'b1;
  end

  // Remember that the clear engine has actually gone busy in this clear.
  always_ff @(posedge clk) begin
    if (rst)                                       seen_low <= 1'b0;
    else if (state == ST_CLR_START)                seen_low <= 1'b0;
    else if (state == ST_CLR_BUSY && !clr_done)    seen_low <= 1'b1;
  end

  // Saturating clear-duration counter, restarted whenever a clear is launched.
  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt <= '0;
    else if (state == ST_IDLE && state_nxt == ST_CLR_START)
      tmo_cnt <= '0;
    else if (state == ST_CLR_BUSY && tmo_cnt != 11'h7FF)
      tmo_cnt <= tmo_cnt + 11'd1;
  end

  // Round-robin pointer: the requester just granted loses the next tie.
  always_ff @(posedge clk) begin
    if (rst)                                               rr_drw_first <= 1'b1;
    else if (state == ST_IDLE && state_nxt == ST_GRANT_DRW) rr_drw_first <= 1'b0;
    else if (state == ST_IDLE && state_nxt == ST_GRANT_TXT) rr_drw_first <= 1'b1;
  end

  // Sticky fault: out-of-range write or clear engine that never finished.
  always_ff @(posedge clk) begin
    if (rst)                      fault <= 1'b0;
    else if (addr_err || tmo_hit) fault <= 1'b1;
  end

  vram_port_mux #(
    .DEPTH (VRAM_DEPTH)
  ) u_port_mux (
    .sel       (port_sel),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .clr_data  (clr_data),
    .drw_we    (drw_we),
    .drw_addr  (drw_addr),
    .drw_data  (drw_data),
    .txt_we    (txt_we),
    .txt_addr  (txt_addr),
    .txt_data  (txt_data),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .addr_err  (addr_err)
  );

endmodule
